// File: rtl/qix_pkg.sv
// qix_pkg: shared constants, palette field layout and the palette expansion
// helper for the Qix video pixel pipeline.
//   PAL_AW    palette RAM address width (2 bank bits + 8 pixel bits)
//   X_BITS    horizontal pixel counter width
//   Y_BITS    line counter width
//   PIPE_LAT  pix_ce stages from display address issue to RGB out
package qix_pkg;

    localparam int PAL_AW   = 10;
    localparam int X_BITS   = 8;
    localparam int Y_BITS   = 8;
    localparam int PIPE_LAT = 3;

    // Palette entry layout: RRGGBBII
    localparam int PAL_R_MSB = 7;
    localparam int PAL_R_LSB = 6;
    localparam int PAL_G_MSB = 5;
    localparam int PAL_G_LSB = 4;
    localparam int PAL_B_MSB = 3;
    localparam int PAL_B_LSB = 2;
    localparam int PAL_I_MSB = 1;
    localparam int PAL_I_LSB = 0;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;

    // Each channel is {colour field, shared intensity}; a zero colour field
    // means the channel is fully off regardless of intensity.
    function automatic rgb_t pal_expand(input logic [7:0] entry);
        rgb_t       v;
        logic [1:0] inten;
        inten = entry[PAL_I_MSB:PAL_I_LSB];
        v.r = (entry[PAL_R_MSB:PAL_R_LSB] == 2'b00) ? 4'h0 : {entry[PAL_R_MSB:PAL_R_LSB], inten};
        v.g = (entry[PAL_G_MSB:PAL_G_LSB] == 2'b00) ? 4'h0 : {entry[PAL_G_MSB:PAL_G_LSB], inten};
        v.b = (entry[PAL_B_MSB:PAL_B_LSB] == 2'b00) ? 4'h0 : {entry[PAL_B_MSB:PAL_B_LSB], inten};
        return v;
    endfunction

endpackage

// File: rtl/qix_palette_ram.sv
// qix_palette_ram: 1024x8 true dual-port palette RAM.
//   Port A (CPU): i_a_addr, i_a_we, i_a_din -> o_a_dout, read-before-write, 1 clk latency
//   Port B (display): i_b_en, i_b_addr -> o_b_dout, read-only, registered
//   i_clk, i_reset: reset clears only the output registers, not the contents
module qix_palette_ram
    import qix_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [PAL_AW-1:0] i_a_addr,
    input  logic              i_a_we,
    input  logic [7:0]        i_a_din,
    output logic [7:0]        o_a_dout,
    input  logic              i_b_en,
    input  logic [PAL_AW-1:0] i_b_addr,
    output logic [7:0]        o_b_dout
);

    logic [7:0] r_mem [0:(1<<PAL_AW)-1];
    logic [7:0] r_a_dout;
    logic [7:0] r_b_dout;

    always_ff @(posedge i_clk) begin
        if (i_a_we) begin
            r_mem[i_a_addr] <= i_a_din;
        end
    end

    // Both read ports sample the array before this edge's write lands, so a
    // same-address collision returns the old entry on either port.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_a_dout <= '0;
        end else begin
            r_a_dout <= r_mem[i_a_addr];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_b_dout <= '0;
        end else if (i_b_en) begin
            r_b_dout <= r_mem[i_b_addr];
        end
    end

    assign o_a_dout = r_a_dout;
    assign o_b_dout = r_b_dout;

endmodule

// File: rtl/qix_video_pixel_pipe.sv
// qix_video_pixel_pipe: framebuffer scanout address generation, pixel fetch,
// palette lookup and registered RGB/sync output.
//   i_clk, i_reset                 system clock, synchronous active-high reset
//   i_pix_ce                       pixel enable (at most 1 in 2 clk)
//   i_crtc_ma/ra/de/hs/vs          CRTC timing
//   o_display_addr, i_display_dout framebuffer scanout port (data 1 clk after addr)
//   i_pal_addr/we/din, o_pal_dout  CPU palette port
//   i_bank_we, i_bank_din          palette bank register write
//   o_red/green/blue, o_hs/vs/de_out  video out, PIPE_LAT pix_ce after address
module qix_video_pixel_pipe
    import qix_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_pix_ce,
    input  logic [13:0]              i_crtc_ma,
    input  logic [4:0]               i_crtc_ra,
    input  logic                     i_crtc_de,
    input  logic                     i_crtc_hs,
    input  logic                     i_crtc_vs,
    output logic [Y_BITS+X_BITS-1:0] o_display_addr,
    input  logic [7:0]               i_display_dout,
    input  logic [PAL_AW-1:0]        i_pal_addr,
    input  logic                     i_pal_we,
    input  logic [7:0]               i_pal_din,
    output logic [7:0]               o_pal_dout,
    input  logic                     i_bank_we,
    input  logic [1:0]               i_bank_din,
    output logic [3:0]               o_red,
    output logic [3:0]               o_green,
    output logic [3:0]               o_blue,
    output logic                     o_hs_out,
    output logic                     o_vs_out,
    output logic                     o_de_out
);

    localparam logic [X_BITS-1:0] X_ONE = 1;

    logic [X_BITS-1:0] r_x;
    logic [Y_BITS-1:0] r_y;
    sync_t             r_sync0;
    sync_t             r_sync_dly [PIPE_LAT];
    logic [7:0]        r_pix;
    logic [1:0]        r_bank;
    rgb_t              r_rgb;

    logic              w_de_rise;
    logic [Y_BITS-1:0] w_y_load;
    logic [7:0]        w_pal_b;
    logic              w_unused;

    assign w_unused  = ^{i_crtc_ma[13:10], i_crtc_ma[4:0], i_crtc_ra[4:3]};

    // r_sync0.de doubles as the previously sampled DE for edge detection.
    assign w_de_rise = i_crtc_de & ~r_sync0.de;
    assign w_y_load  = {i_crtc_ma[9:5], i_crtc_ra[2:0]};

    // Stage 0: line/pixel counters; the address register is {y, x} itself.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_x     <= '0;
            r_y     <= '0;
            r_sync0 <= '0;
        end else if (i_pix_ce) begin
            r_sync0 <= {i_crtc_hs, i_crtc_vs, i_crtc_de};
            if (w_de_rise) begin
                r_y <= w_y_load;
                r_x <= '0;
            end else if (i_crtc_de) begin
                r_x <= r_x + X_ONE;
            end
        end
    end

    assign o_display_addr = {r_y, r_x};

    // Stage 1: capture the framebuffer pixel for the address issued last pix_ce.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pix <= '0;
        end else if (i_pix_ce) begin
            r_pix <= i_display_dout;
        end
    end

    // Bank register runs every clk; stage 2 only samples it on pix_ce, so a
    // bank change never splits a pixel.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_bank <= '0;
        end else if (i_bank_we) begin
            r_bank <= i_bank_din;
        end
    end

    // Stage 2: palette lookup (registered inside the RAM).
    qix_palette_ram u_palette_ram (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_a_addr (i_pal_addr),
        .i_a_we   (i_pal_we),
        .i_a_din  (i_pal_din),
        .o_a_dout (o_pal_dout),
        .i_b_en   (i_pix_ce),
        .i_b_addr ({r_bank, r_pix}),
        .o_b_dout (w_pal_b)
    );

    // Stage 3 plus the sync/DE delay line. Entry k of the delay line holds the
    // stage-0 timing k+1 pix_ce later, so entry PIPE_LAT-2 belongs to the pixel
    // being coloured now and entry PIPE_LAT-1 lines up with r_rgb.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                r_sync_dly[i] <= '0;
            end
            r_rgb <= '0;
        end else if (i_pix_ce) begin
            r_sync_dly[0] <= r_sync0;
            for (int i = 1; i < PIPE_LAT; i++) begin
                r_sync_dly[i] <= r_sync_dly[i-1];
            end
            r_rgb <= r_sync_dly[PIPE_LAT-2].de ? pal_expand(w_pal_b) : '0;
        end
    end

    assign o_red    = r_rgb.r;
    assign o_green  = r_rgb.g;
    assign o_blue   = r_rgb.b;
    assign o_hs_out = r_sync_dly[PIPE_LAT-1].hs;
    assign o_vs_out = r_sync_dly[PIPE_LAT-1].vs;
    assign o_de_out = r_sync_dly[PIPE_LAT-1].de;

endmodule
